// File: rtl/multiplier_stg_0_add_pkg.sv
// Shared definitions for the repeated-addition multiplier: FSM encodings and
// the product width helper used by the top level and its datapath.
package multiplier_stg_0_add_pkg;

    localparam int L_state = 2;

    typedef enum logic [L_state-1:0] {
        S_idle = 2'd0,
        S_1    = 2'd1,
        S_done = 2'd2
    } state_t;

    function automatic int product_width(input int l_mcnd, input int l_mplr);
        return l_mcnd + l_mplr;
    endfunction

endpackage

// File: rtl/multiplier_stg_0_add_datapath.sv
// Multiplicand register, multiplier down-counter and product accumulator.
// Registers change only on load or add; Clear_product zeroes the result alone.
module multiplier_stg_0_add_datapath
    import multiplier_stg_0_add_pkg::*;
#(
    parameter int L_mcnd = 8,
    parameter int L_mplr = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     Load_words,
    input  logic                                     Add,
    input  logic                                     Clear_product,
    input  logic [L_mcnd-1:0]                        word1,
    input  logic [L_mplr-1:0]                        word2,
    output logic [product_width(L_mcnd, L_mplr)-1:0] product,
    output logic                                     counter_is_one
);

    localparam int L_prod = product_width(L_mcnd, L_mplr);

    logic [L_mcnd-1:0] multiplicand;
    logic [L_mplr-1:0] counter;

    assign counter_is_one = (counter == L_mplr'(1));

    always_ff @(posedge clock) begin
        if (reset) begin
            multiplicand <= '0;
            counter      <= '0;
            product      <= '0;
        end else if (Load_words) begin
            multiplicand <= word1;
            counter      <= word2;
            product      <= '0;
        end else if (Clear_product) begin
            product      <= '0;
        end else if (Add) begin
            // Product width covers the full range, so the sum never wraps.
            product      <= product + L_prod'(multiplicand);
            counter      <= counter - L_mplr'(1);
        end
    end

endmodule

// File: rtl/multiplier_stg_0_add.sv
// Sequential unsigned multiplier by repeated addition with a Start/Ready
// handshake; the control FSM lives here, arithmetic in the datapath.
module multiplier_stg_0_add
    import multiplier_stg_0_add_pkg::*;
#(
    parameter int L_mcnd = 8,
    parameter int L_mplr = 4
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     Start,
    input  logic [L_mcnd-1:0]                        word1,
    input  logic [L_mplr-1:0]                        word2,
    output logic [product_width(L_mcnd, L_mplr)-1:0] product,
    output logic                                     Ready,
    output logic [L_state-1:0]                       dbg_state
);

    // Handshake: Start is sampled on a rising edge only while Ready is high;
    // Ready stays low for the whole add phase and the result in product is
    // valid and held from the cycle Ready rises until the next accepted Start.

    state_t state, next_state;
    logic   load_words, add, clear_product, counter_is_one;

    always_ff @(posedge clock) begin
        if (reset) state <= S_idle;
        else       state <= next_state;
    end

    always_comb begin
        next_state    = state;
        load_words    = 1'b0;
        add           = 1'b0;
        clear_product = 1'b0;
        case (state)
            S_idle, S_done: begin
                if (Start) begin
                    if (word1 == '0 || word2 == '0) begin
                        clear_product = 1'b1;
                        next_state    = S_done;
                    end else begin
                        load_words    = 1'b1;
                        next_state    = S_1;
                    end
                end
            end
            S_1: begin
                add = 1'b1;
                if (counter_is_one) next_state = S_done;
            end
            default: next_state = S_idle;
        endcase
    end

    assign Ready     = (state == S_idle && !reset) || (state == S_done);
    assign dbg_state = state;

    multiplier_stg_0_add_datapath #(
        .L_mcnd(L_mcnd),
        .L_mplr(L_mplr)
    ) u_datapath (
        .clock         (clock),
        .reset         (reset),
        .Load_words    (load_words),
        .Add           (add),
        .Clear_product (clear_product),
        .word1         (word1),
        .word2         (word2),
        .product       (product),
        .counter_is_one(counter_is_one)
    );

endmodule

// File: tb/tb_multiplier_stg_0_add.sv
// Self-checking bench for multiplier_stg_0_add: directed cases plus exhaustive
// and random operands against a plain-arithmetic reference model.
module tb_multiplier_stg_0_add;

    localparam int L_mcnd = 8;
    localparam int L_mplr = 4;
    localparam int L_prod = L_mcnd + L_mplr;
    localparam int BUDGET = 40;

    logic              clock;
    logic              reset;
    logic              Start;
    logic [L_mcnd-1:0] word1;
    logic [L_mplr-1:0] word2;
    logic [L_prod-1:0] product;
    logic              Ready;
    logic [1:0]        dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [L_prod-1:0] exp_q[$];

    multiplier_stg_0_add #(.L_mcnd(L_mcnd), .L_mplr(L_mplr)) dut (
        .clock    (clock),
        .reset    (reset),
        .Start    (Start),
        .word1    (word1),
        .word2    (word2),
        .product  (product),
        .Ready    (Ready),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launch one operation and wait for Ready; optionally toggle Start randomly
    // while busy. Checks product and the edge count against the model.
    task automatic run_op(input logic [L_mcnd-1:0] w1, input logic [L_mplr-1:0] w2,
                          input bit noise, input string tag);
        int lat_exp;
        int edges;
        bit done;
        logic [L_prod-1:0] exp_p;
        exp_q.push_back(L_prod'(int'(w1) * int'(w2)));
        lat_exp = (w1 == 0 || w2 == 0) ? 1 : int'(w2) + 1;
        @(negedge clock);
        word1 = w1;
        word2 = w2;
        Start = 1'b1;
        edges = 0;
        done  = 1'b0;
        while (!done && edges < BUDGET) begin
            @(negedge clock);
            edges++;
            if (Ready) begin
                done  = 1'b1;
                Start = 1'b0;
            end else begin
                Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                word1 = noise ? L_mcnd'($urandom) : word1;
                word2 = noise ? L_mplr'($urandom) : word2;
            end
        end
        exp_p = exp_q.pop_front();
        if (!done) check_eq({tag, "_timeout"}, 32'(edges), 32'(lat_exp));
        else begin
            check_eq({tag, "_latency"}, 32'(edges), 32'(lat_exp));
            check_eq({tag, "_product"}, 32'(product), 32'(exp_p));
        end
    endtask

    initial begin
        reset = 1'b1;
        Start = 1'b1;
        word1 = 8'd5;
        word2 = 4'd3;
        // Reset has priority over a held Start.
        repeat (2) @(posedge clock);
        #1;
        check_eq("reset_ready_low", 32'(Ready), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        Start = 1'b0;
        #1;
        check_eq("reset_product", 32'(product), 32'd0);
        check_eq("reset_state", 32'(dbg_state), 32'd0);
        check_eq("reset_ready", 32'(Ready), 32'd1);

        // Basic, then hold with Start low
        run_op(8'd5, 4'd3, 1'b0, "basic");
        repeat (3) @(negedge clock);
        check_eq("basic_hold_product", 32'(product), 32'd15);
        check_eq("basic_hold_ready", 32'(Ready), 32'd1);
        check_eq("basic_hold_state", 32'(dbg_state), 32'd2);

        run_op(8'd0, 4'd9, 1'b0, "zero_w1");
        run_op(8'd200, 4'd0, 1'b0, "zero_w2");
        run_op(8'd255, 4'd15, 1'b0, "max");

        // Back-to-back: Start held in S_done relaunches immediately
        run_op(8'd3, 4'd2, 1'b0, "b2b_first");
        @(negedge clock);
        word1 = 8'd9;
        word2 = 4'd4;
        Start = 1'b1;
        @(negedge clock);
        check_eq("b2b_ready_drop", 32'(Ready), 32'd0);
        check_eq("b2b_state", 32'(dbg_state), 32'd1);
        Start = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("b2b_ready", 32'(Ready), 32'd1);
        check_eq("b2b_product", 32'(product), 32'd36);

        // Reset on the 5th add edge
        @(negedge clock);
        word1 = 8'd100;
        word2 = 4'd12;
        Start = 1'b1;
        @(negedge clock);
        Start = 1'b0;
        repeat (4) @(negedge clock);
        check_eq("abort_busy", 32'(Ready), 32'd0);
        check_eq("abort_partial", 32'(product), 32'd400);
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort_product", 32'(product), 32'd0);
        check_eq("abort_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        #1;
        check_eq("abort_ready", 32'(Ready), 32'd1);
        run_op(8'd7, 4'd2, 1'b0, "after_abort");

        // Exhaustive nonzero operands with Start noise while busy
        for (int a = 1; a < 256; a++)
            for (int b = 1; b < 16; b++)
                run_op(L_mcnd'(a), L_mplr'(b), 1'b1, "exh");

        // Random operands, zeros included
        for (int i = 0; i < 300; i++)
            run_op(L_mcnd'($urandom_range(0, 255)), L_mplr'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
